vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Parametrised VGA/DVI raster timing generator, successor to the fixed 640x480 sync generator in the VGA demo designs. It produces registered hsync, vsync, data-enable and pixel coordinates for any resolution and porch set. Sync polarity is selectable, and a pixel-clock enable supports divided pixel rates from a faster system clock. It also emits line/frame strobes and a frame counter for animation logic. It sits between the PLL-derived clock and the pixel-generation logic in both the FPGA top level and the TT user designs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, 1 = active-high hsync, 0 = active-low
- VSYNC_POL, 0, 1 = active-high vsync, 0 = active-low
- CNT_W, 10, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, width of frame counter

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, synchronous, active-low
- pix_en  in  1  pixel advance enable; tie high for one pixel per clk
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  high when (x,y) is in the active area
- x  out  CNT_W  current horizontal position 0..H_TOTAL-1
- y  out  CNT_W  current vertical position 0..V_TOTAL-1
- line_start  out  1  one-clk strobe when x becomes 0
- frame_start  out  1  one-clk strobe when (x,y) becomes (0,0)
- frame_cnt  out  FRAME_W  completed-frame count, wraps

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 x 525.
- Internal counters h, v advance only on clk edges with pix_en=1. h wraps H_TOTAL-1 -> 0. On that wrap v increments, wrapping V_TOTAL-1 -> 0. No other wrap points: exactly V_TOTAL lines per frame.
- Decode of the counter state is registered into all outputs on the same edge, so x, y, de, hsync and vsync always describe the same pixel.
- de = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync is active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. vsync is active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. Active level = POL; inactive = ~POL.
- x and y are raw counters. They keep counting through blanking and are not clamped.
- line_start is high for exactly one clk after the update that loads x=0. frame_start is likewise high for one clk after the update that loads (0,0). Both are low while pix_en holds outputs, so they are never stretched.
- frame_cnt increments by 1, modulo 2^FRAME_W, on the same update that raises frame_start.
- Reset: h=v=0, x=y=0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=frame_start=0, frame_cnt=0. Reset overrides pix_en. Reset mid-frame abandons the frame without a strobe.
- First update after reset loads (0,0) with de=1. line_start=frame_start=1 on that update; frame_cnt stays 0 (reset frame is frame 0; increment is suppressed for this first update only).

## Timing
- Latency: one clk from a pix_en=1 edge to the outputs reflecting the new pixel.
- pix_en=0: all outputs hold their values; strobes drop to 0 after one clk.
- pix_en may toggle arbitrarily. The raster advances exactly one pixel per enabled clk, with no skipped or repeated pixel states.
- Period with pix_en=1 continuously: line_start every H_TOTAL clks, frame_start every H_TOTAL*V_TOTAL clks (420000 at defaults).

## Test plan
- Defaults, pix_en=1: measure 800 clks between line_start pulses and 420000 clks between frame_start pulses. hsync must be low exactly for x 656..751; vsync must be low exactly for y 490..491; de must be high for 640 x 480 = 307200 clks per frame.
- Small config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1, VSYNC_POL=1), pix_en=1: require H_TOTAL=8 and V_TOTAL=6; hsync high only at x=5,6; vsync high only at y=4; full (x,y) sequence checked against a model for 3 frames.
- pix_en pattern 1,0,0,1 repeating: outputs must advance once per enable and hold otherwise. Strobes must be exactly one clk wide, and the frame period must equal 3x the continuous period.
- Reset asserted at (x,y)=(300,200) for 2 clks: outputs must take reset values on the first clk. After release, the first enabled clk must give (0,0), de=1, frame_start=1, frame_cnt=0.
- FRAME_W=2 with the small config: frame_cnt must follow 0,1,2,3,0 across successive frame_start pulses.

Source files
------------

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: parametrised VGA/DVI raster timing with registered sync, de,
// coordinates, line/frame strobes and a frame counter; advances on pix_en.
module vga_timing_generator #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CNT_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = HSYNC_POL != 0;
    localparam logic VS_ON = VSYNC_POL != 0;

    logic [CNT_W-1:0]   r_h, r_v, r_x, r_y;
    logic [FRAME_W-1:0] r_fc;
    logic               r_hs, r_vs, r_de, r_ls, r_fs, r_first;
    logic               w_h_last, w_v_last, w_org, w_hs_act, w_vs_act;

    // r_h/r_v name the pixel the next enabled edge will present on the outputs
    assign w_h_last = r_h == H_LAST;
    assign w_v_last = r_v == V_LAST;
    assign w_org    = (r_h == '0) && (r_v == '0);
    assign w_hs_act = (r_h >= HS_B) && (r_h < HS_E);
    assign w_vs_act = (r_v >= VS_B) && (r_v < VS_E);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h     <= '0;
            r_v     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_de    <= 1'b0;
            r_hs    <= ~HS_ON;
            r_vs    <= ~VS_ON;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
            r_fc    <= '0;
            r_first <= 1'b1;
        end else if (pix_en) begin
            r_h     <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last)
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            r_x     <= r_h;
            r_y     <= r_v;
            r_de    <= (r_h < H_ACT) && (r_v < V_ACT);
            r_hs    <= w_hs_act ? HS_ON : ~HS_ON;
            r_vs    <= w_vs_act ? VS_ON : ~VS_ON;
            r_ls    <= r_h == '0;
            r_fs    <= w_org;
            // the frame entered straight out of reset is frame 0
            if (w_org && !r_first)
                r_fc <= r_fc + 1'b1;
            r_first <= 1'b0;
        end else begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end
    end

    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fc;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: scoreboard bench for a small raster (H 4/1/2/1, V 3/1/1/1,
// active-high syncs, 2-bit frame count) plus line-level checks of the default 800x525 timing.
module tb_vga_timing_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst_n, s_en, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [1:0] s_fc;
    logic       d_rst_n, d_en, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(10), .FRAME_W(2)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .pix_en(s_en), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    vga_timing_generator u_dflt (
        .clk(clk), .rst_n(d_rst_n), .pix_en(d_en), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de, hs, vs, ls, fs;
        logic [1:0] fc;
    } obs_t;

    obs_t s_now;
    assign s_now = {s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs, s_fc};

    obs_t q[$];
    obs_t e;
    int   n_chk = 0, n_fail = 0;
    int   mh, mv, mfc, cyc;
    bit   mfirst;
    int   ls_t[$], fs_t[$], fc_h[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // model of the small raster: expected outputs are queued as stimulus is driven
    task automatic s_step(input bit rst, input bit en);
        obs_t got;
        s_rst_n = !rst;
        s_en    = en;
        if (rst) begin
            mh = 0; mv = 0; mfc = 0; mfirst = 1;
            e = '0;
        end else if (en) begin
            e.x  = 10'(mh);
            e.y  = 10'(mv);
            e.de = (mh < 4) && (mv < 3);
            e.hs = (mh == 5) || (mh == 6);
            e.vs = (mv == 4);
            e.ls = (mh == 0);
            e.fs = (mh == 0) && (mv == 0);
            if (e.fs && !mfirst) mfc = (mfc + 1) % 4;
            mfirst = 0;
            e.fc = 2'(mfc);
            mh++;
            if (mh == 8) begin
                mh = 0;
                mv = (mv + 1) % 6;
            end
        end else begin
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = q.pop_front();
        check("small_pixel", 32'(s_now), 32'(got));
        if (s_ls) ls_t.push_back(cyc);
        if (s_fs) begin
            fs_t.push_back(cyc);
            fc_h.push_back(int'(s_fc));
        end
    endtask

    task automatic clr_hist();
        ls_t.delete();
        fs_t.delete();
        fc_h.delete();
    endtask

    task automatic chk_period(input string tag, input int t[$], input int per, input int min_n);
        check({tag, "_count_ok"}, 32'(t.size() >= min_n), 32'd1);
        for (int i = 1; i < t.size(); i++)
            check(tag, 32'(t[i] - t[i-1]), 32'(per));
    endtask

    initial begin
        int de_cnt, k0;
        int exp_fc[5] = '{0, 1, 2, 3, 0};
        cyc = 0;
        s_rst_n = 1'b0; s_en = 1'b0;
        d_rst_n = 1'b0; d_en = 1'b1;

        s_step(1, 0);
        s_step(1, 1);
        clr_hist();
        for (int i = 0; i < 240; i++) s_step(0, 1);
        chk_period("small_line_period", ls_t, 8, 30);
        chk_period("small_frame_period", fs_t, 48, 5);
        check("small_fc_pulses", 32'(fc_h.size()), 32'd5);
        for (int i = 0; i < fc_h.size() && i < 5; i++)
            check("small_frame_cnt_seq", 32'(fc_h[i]), 32'(exp_fc[i]));

        clr_hist();
        for (int i = 0; i < 432; i++) s_step(0, (i % 3) == 0);
        chk_period("gated_line_period", ls_t, 24, 17);
        chk_period("gated_frame_period", fs_t, 144, 3);

        for (int i = 0; i < 20; i++) s_step(0, 1);
        s_step(1, 1);
        check("midreset_x", 32'(s_x), 32'd0);
        check("midreset_de", 32'(s_de), 32'd0);
        s_step(1, 1);
        s_step(0, 1);
        check("after_reset_fs", 32'(s_fs), 32'd1);
        check("after_reset_fc", 32'(s_fc), 32'd0);
        check("after_reset_de", 32'(s_de), 32'd1);
        for (int i = 0; i < 60; i++) s_step(0, (i % 2) == 0);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        s_rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("dflt_reset", 32'({d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs}), 32'({10'd0, 10'd0, 5'b01100}));
        check("dflt_reset_fc", 32'(d_fc), 32'd0);
        d_rst_n = 1'b1;
        de_cnt = 0;
        k0 = -1;
        for (int k = 0; k < 1800; k++) begin
            int hx;
            logic [24:0] exp_v;
            @(posedge clk); #1;
            hx = k % 800;
            exp_v = {10'(hx), 10'(k / 800), hx < 640, !(hx >= 656 && hx < 752), 1'b1,
                     hx == 0, k == 0};
            check("dflt_pixel", 32'({d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs}), 32'(exp_v));
            if (k < 800 && d_de) de_cnt++;
            if (d_ls) begin
                if (k0 >= 0) check("dflt_line_period", 32'(k - k0), 32'd800);
                k0 = k;
            end
        end
        check("dflt_de_per_line", 32'(de_cnt), 32'd640);
        check("dflt_fc", 32'(d_fc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
